task_fifo_scheduler: RTL and testbench
======================================

// Module: task_fifo_scheduler
// PURPOSE
//  Front-end scheduler for the per-RPU TaskFIFOs that feed the task distributor.
//  - Accepts push/pop requests from TREE_NUM per-tree requesters.
//  - Routes each tree to one TaskFIFO through a configurable tree->FIFO map.
//  - Arbitrates round-robin; at most one write per FIFO per cycle.
//  - Sequences safe remapping: per-tree ordering is never broken by a map change.
// PARAMETERS
//  PTW            16                  payload data width
//  LEVEL          4                   RPU / TaskFIFO count
//  LEVEL_BITS     $clog2(LEVEL)       FIFO index width
//  TREE_NUM       4                   requester (tree) count
//  TREE_NUM_BITS  $clog2(TREE_NUM)    tree id width
// PORTS
//  i_clk          in   1                    clock
//  i_arst_n       in   1                    async active-low reset
//  i_req_valid    in   [TREE_NUM]           request valid per tree
//  i_req_push     in   [TREE_NUM]           1=push, 0=pop
//  i_req_data     in   [PTW] x TREE_NUM     push data, ignored for pop
//  o_req_ready    out  [TREE_NUM]           grant; transfer = valid & ready
//  o_fifo_push    out  [LEVEL]              TaskFIFO write strobe
//  o_fifo_data    out  [PTW+TREE_NUM_BITS+1] x LEVEL   {push,treeId,data}
//  i_fifo_full    in   [LEVEL]              TaskFIFO full
//  i_fifo_empty   in   [LEVEL]              TaskFIFO empty
//  i_cfg_we       in   1                    map write request, 1-cycle pulse
//  i_cfg_tree     in   [TREE_NUM_BITS]      tree to remap
//  i_cfg_fifo     in   [LEVEL_BITS]         new target FIFO
//  o_cfg_busy     out  1                    remap pending
// BEHAVIOUR
//  Reset values
//  - All outputs 0.
//  - map[t] = t % LEVEL; rr_ptr = 0; cfg FSM = CFG_IDLE.
//  Grant (combinational, zero latency)
//  - Tree t is eligible when: i_req_valid[t], !i_fifo_full[map[t]], and t is not the pending-remap tree.
//  - Scan trees from rr_ptr upward with wrap-around.
//  - Grant each eligible tree whose target FIFO is not already claimed this cycle.
//  - Each granted tree drives o_req_ready[t]=1, o_fifo_push[map[t]]=1, and
//    o_fifo_data[map[t]] = {i_req_push[t], t, push ? i_req_data[t] : '0}.
//  - Data width = PTW+TREE_NUM_BITS+1, matching the distributor's TaskFIFO entry.
//  Round-robin pointer
//  - On any grant: rr_ptr <= (last granted index in scan order)+1, mod TREE_NUM.
//  - No grant: rr_ptr holds.
//  Remap FSM
//  - CFG_IDLE:
//    - i_cfg_we latches {tree, fifo}.
//    - If the new fifo equals map[tree]: no-op, stay in CFG_IDLE, busy stays 0.
//    - Otherwise: -> CFG_DRAIN, and o_cfg_busy=1 from the next cycle.
//  - CFG_DRAIN:
//    - The pending tree is never granted.
//    - Wait until i_fifo_empty[old map] is high AND o_fifo_push[old map] is low that cycle.
//    - Then -> CFG_COMMIT.
//  - CFG_COMMIT (1 cycle): map[tree] <= new fifo; -> CFG_IDLE; busy drops the following cycle.
//  - i_cfg_we while busy: ignored (no queueing); the bench checks that the map is unchanged.
//  Boundaries
//  - Target FIFO full: request stalls, valid is held by the requester, no data loss.
//  - Several trees map to the same FIFO: exactly one is granted per cycle, RR-fair.
//    Starvation bound: TREE_NUM-1 cycles while the FIFO is not full.
//  - Pending tree's old FIFO never drains (downstream stalled): busy stays high indefinitely, by design.
//  - Reset mid-remap: returns to CFG_IDLE with the map at reset defaults; the pending write is lost.
//  - i_req_push is sampled only on a grant cycle.
// STRUCTURE
//  - Package bmw_task_pkg:
//    - task_entry_t {logic push; treeId; data}.
//    - Op encoding OP_PUSH=1, OP_POP=0.
//    - cfg_state_t {CFG_IDLE, CFG_DRAIN, CFG_COMMIT}.
//  - Sub-module task_rr_pick: rotating multi-grant picker.
//    - In: eligible vector, target per requester, rr_ptr.
//    - Out: grant vector, next rr_ptr.
//  - Map table, FSM and output muxing live in the top module.
// TESTING
//  1 Reset defaults, LEVEL=4, TREE_NUM=4; trees 0..3 push data 0x11..0x44
//    -> same-cycle o_fifo_push=4'b1111; fifo k receives {1,k,0x11*(k+1)}.
//  2 Map trees 0,1,2 to FIFO 0; all three valid for 6 cycles
//    -> grants follow 0,1,2,0,1,2; one push per cycle on FIFO 0.
//  3 i_fifo_full[1] held high 5 cycles with tree 1 valid
//    -> o_req_ready[1]=0 for 5 cycles; granted in the cycle full drops.
//  4 Remap tree 2 from FIFO 2 to FIFO 3 while FIFO 2 is non-empty for 3 cycles
//    -> busy=1, tree 2 blocked; commit 1 cycle after empty; later pushes go to FIFO 3.
//  5 i_cfg_we during busy, and i_cfg_we with the same fifo
//    -> both ignored; map unchanged; busy timing unaffected.
//  6 Assert i_arst_n=0 in CFG_DRAIN
//    -> all outputs 0 at once; after release, map = defaults and busy=0.

Source files
------------

// File: rtl/bmw_task_pkg.sv
// Shared types for the TaskFIFO front-end scheduler: entry layout,
// request op encoding and the remap sequencer state.
package bmw_task_pkg;

  localparam int PTW_DEF           = 16;
  localparam int LEVEL_DEF         = 4;
  localparam int LEVEL_BITS_DEF    = $clog2(LEVEL_DEF);
  localparam int TREE_NUM_DEF      = 4;
  localparam int TREE_NUM_BITS_DEF = $clog2(TREE_NUM_DEF);

  // Request op carried in the top bit of every TaskFIFO entry.
  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PUSH = 1'b1
  } op_t;

  // Remap sequencer: IDLE -> DRAIN (wait for old FIFO to empty) -> COMMIT.
  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_DRAIN  = 2'd1,
    CFG_COMMIT = 2'd2
  } cfg_state_t;

  // TaskFIFO entry as seen by the distributor (default widths).
  typedef struct packed {
    logic                         push;
    logic [TREE_NUM_BITS_DEF-1:0] treeId;
    logic [PTW_DEF-1:0]           data;
  } task_entry_t;

endpackage

// File: rtl/task_rr_pick.sv
// Rotating multi-grant picker: scans requesters from rrPtr upward with
// wrap-around and grants every eligible requester whose target has not
// already been claimed in this scan. nextPtr points just past the last
// grant in scan order, or holds when nothing is granted.
module task_rr_pick #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int NB = $clog2(N),
  parameter int MB = $clog2(M)
) (
  input  logic [N-1:0]         eligible,
  input  logic [N-1:0][MB-1:0] target,
  input  logic [NB-1:0]        rrPtr,
  output logic [N-1:0]         grant,
  output logic [NB-1:0]        nextPtr
);

  logic [M-1:0] claimed;
  logic         anyGrant;
  int           idx;
  int           lastIdx;

  // Single rotating scan; first requester in scan order wins each target.
  always_comb begin
    grant    = '0;
    claimed  = '0;
    anyGrant = 1'b0;
    lastIdx  = 0;
    idx      = 0;
    nextPtr  = rrPtr;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rrPtr) + k) % N;
      if (eligible[idx] && !claimed[target[idx]]) begin
        grant[idx]              = 1'b1;
        claimed[target[idx]]    = 1'b1;
        lastIdx                 = idx;
        anyGrant                = 1'b1;
      end
    end
    if (anyGrant) begin
      nextPtr = NB'((lastIdx + 1) % N);
    end
  end

endmodule

// File: rtl/task_fifo_scheduler.sv
// Front-end scheduler for the per-RPU TaskFIFOs. Routes each tree's
// push/pop request to its mapped FIFO, arbitrates round-robin with at
// most one write per FIFO per cycle, and sequences remaps so that a
// tree's entries never straddle two FIFOs out of order.
module task_fifo_scheduler
  import bmw_task_pkg::*;
#(
  parameter int PTW           = PTW_DEF,
  parameter int LEVEL         = LEVEL_DEF,
  parameter int LEVEL_BITS    = $clog2(LEVEL),
  parameter int TREE_NUM      = TREE_NUM_DEF,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                                         i_clk,
  input  logic                                         i_arst_n,
  // Requests: a transfer happens when i_req_valid[t] & o_req_ready[t].
  // Requesters hold valid (and payload) until ready is seen.
  input  logic [TREE_NUM-1:0]                          i_req_valid,
  input  logic [TREE_NUM-1:0]                          i_req_push,
  input  logic [TREE_NUM-1:0][PTW-1:0]                 i_req_data,
  output logic [TREE_NUM-1:0]                          o_req_ready,
  output logic [LEVEL-1:0]                             o_fifo_push,
  output logic [LEVEL-1:0][PTW+TREE_NUM_BITS:0]        o_fifo_data,
  input  logic [LEVEL-1:0]                             i_fifo_full,
  input  logic [LEVEL-1:0]                             i_fifo_empty,
  input  logic                                         i_cfg_we,
  input  logic [TREE_NUM_BITS-1:0]                     i_cfg_tree,
  input  logic [LEVEL_BITS-1:0]                        i_cfg_fifo,
  output logic                                         o_cfg_busy,
  output cfg_state_t                                   o_cfgState
);

  logic [TREE_NUM-1:0][LEVEL_BITS-1:0] mapTbl;
  logic [TREE_NUM_BITS-1:0]            rrPtr;
  logic [TREE_NUM_BITS-1:0]            rrNext;
  cfg_state_t                          cfgState;
  logic [TREE_NUM_BITS-1:0]            pendTree;
  logic [LEVEL_BITS-1:0]               pendFifo;
  logic                                cfgBusy;
  logic [TREE_NUM-1:0]                 eligible;
  logic [TREE_NUM-1:0]                 grant;
  logic [LEVEL_BITS-1:0]               oldFifo;

  // Eligibility: valid, target not full, not the tree being remapped.
  // Gated by reset so every output is quiet while reset is held.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      eligible[t] = i_arst_n && i_req_valid[t] && !i_fifo_full[mapTbl[t]] &&
                    !((cfgState != CFG_IDLE) && (pendTree == TREE_NUM_BITS'(t)));
    end
  end

  task_rr_pick #(
    .N  (TREE_NUM),
    .M  (LEVEL),
    .NB (TREE_NUM_BITS),
    .MB (LEVEL_BITS)
  ) u_pick (
    .eligible (eligible),
    .target   (mapTbl),
    .rrPtr    (rrPtr),
    .grant    (grant),
    .nextPtr  (rrNext)
  );

  assign o_req_ready = grant;
  assign oldFifo     = mapTbl[pendTree];
  assign o_cfg_busy  = cfgBusy;
  assign o_cfgState  = cfgState;

  // Route each granted tree onto its FIFO's write port; pops carry zero data.
  always_comb begin
    o_fifo_push = '0;
    o_fifo_data = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      if (grant[t]) begin
        o_fifo_push[mapTbl[t]] = 1'b1;
        o_fifo_data[mapTbl[t]] = {i_req_push[t], TREE_NUM_BITS'(t),
                                  (op_t'(i_req_push[t]) == OP_PUSH) ? i_req_data[t] : PTW'(0)};
      end
    end
  end

  // Round-robin pointer advances past the last grant, holds otherwise.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rrPtr <= '0;
    end else begin
      rrPtr <= rrNext;
    end
  end

  // Remap sequencer and map table: drain the old FIFO, then commit.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cfgState <= CFG_IDLE;
      pendTree <= '0;
      pendFifo <= '0;
      cfgBusy  <= 1'b0;
      for (int t = 0; t < TREE_NUM; t++) begin
        mapTbl[t] <= LEVEL_BITS'(t % LEVEL);
      end
    end else begin
      case (cfgState)
        CFG_IDLE: begin
          // A request that does not change the mapping is dropped.
          if (i_cfg_we && (i_cfg_fifo != mapTbl[i_cfg_tree])) begin
            pendTree <= i_cfg_tree;
            pendFifo <= i_cfg_fifo;
            cfgState <= CFG_DRAIN;
            cfgBusy  <= 1'b1;
          end
        end
        CFG_DRAIN: begin
          // Old FIFO must be empty with nothing landing in it this cycle.
          if (i_fifo_empty[oldFifo] && !o_fifo_push[oldFifo]) begin
            cfgState <= CFG_COMMIT;
          end
        end
        CFG_COMMIT: begin
          mapTbl[pendTree] <= pendFifo;
          cfgState         <= CFG_IDLE;
          cfgBusy          <= 1'b0;
        end
        default: begin
          cfgState <= CFG_IDLE;
          cfgBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_fifo_scheduler.sv
// Bench for task_fifo_scheduler: reset check, hand-computed vector table,
// directed remap/reset sequences and a randomized run against a queue-free
// behavioural model of the grant and remap rules.
module tb_task_fifo_scheduler;
  import bmw_task_pkg::*;

  logic                 clk;
  logic                 rstN;
  logic [3:0]           valid;
  logic [3:0]           push;
  logic [3:0][15:0]     data;
  logic [3:0]           ready;
  logic [3:0]           fifoPush;
  logic [3:0][18:0]     fifoData;
  logic [3:0]           full;
  logic [3:0]           empty;
  logic                 cfgWe;
  logic [1:0]           cfgTree;
  logic [1:0]           cfgFifo;
  logic                 busy;
  cfg_state_t           dbgState;

  int nChecks = 0;
  int nFail   = 0;

  task_fifo_scheduler dut (
    .i_clk        (clk),
    .i_arst_n     (rstN),
    .i_req_valid  (valid),
    .i_req_push   (push),
    .i_req_data   (data),
    .o_req_ready  (ready),
    .o_fifo_push  (fifoPush),
    .o_fifo_data  (fifoData),
    .i_fifo_full  (full),
    .i_fifo_empty (empty),
    .i_cfg_we     (cfgWe),
    .i_cfg_tree   (cfgTree),
    .i_cfg_fifo   (cfgFifo),
    .o_cfg_busy   (busy),
    .o_cfgState   (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [1:0]       mMap[4];
  int               mRr;
  bit               mPend;
  bit               mCommit;
  int               mPTree;
  int               mPFifo;
  logic [3:0]       mExpReady;
  logic [3:0]       mExpPush;
  logic [3:0][18:0] mExpData;
  bit               mAny;
  int               mLast;

  task automatic modelReset();
    for (int t = 0; t < 4; t++) mMap[t] = 2'(t % 4);
    mRr = 0; mPend = 0; mCommit = 0; mPTree = 0; mPFifo = 0;
  endtask

  task automatic modelEval();
    bit [3:0]    claimed;
    task_entry_t e;
    int          t;
    int          f;
    claimed = '0; mExpReady = '0; mExpPush = '0; mExpData = '0; mAny = 0; mLast = 0;
    for (int k = 0; k < 4; k++) begin
      t = (mRr + k) % 4;
      f = int'(mMap[t]);
      if (valid[t] && !full[f] && !(mPend && t == mPTree) && !claimed[f]) begin
        claimed[f]   = 1'b1;
        mExpReady[t] = 1'b1;
        mExpPush[f]  = 1'b1;
        e.push       = push[t];
        e.treeId     = 2'(t);
        e.data       = push[t] ? data[t] : 16'h0000;
        mExpData[f]  = e;
        mLast        = t;
        mAny         = 1;
      end
    end
  endtask

  task automatic modelAdvance();
    int oldF;
    if (mAny) mRr = (mLast + 1) % 4;
    if (!mPend) begin
      if (cfgWe && cfgFifo != mMap[cfgTree]) begin
        mPend = 1; mCommit = 0; mPTree = int'(cfgTree); mPFifo = int'(cfgFifo);
      end
    end else if (!mCommit) begin
      oldF = int'(mMap[mPTree]);
      if (empty[oldF] && !mExpPush[oldF]) mCommit = 1;
    end else begin
      mMap[mPTree] = 2'(mPFifo);
      mPend = 0; mCommit = 0;
    end
  endtask

  // Called right after inputs are driven at a negedge.
  task automatic cycleBegin(input string tag);
    #2;
    modelEval();
    check({tag, " ready"}, 128'(ready), 128'(mExpReady));
    check({tag, " push"},  128'(fifoPush), 128'(mExpPush));
    check({tag, " data"},  128'(fifoData), 128'(mExpData));
    check({tag, " busy"},  128'(busy), 128'(mPend));
  endtask

  task automatic cycleEnd();
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic stepModel(input string tag);
    cycleBegin(tag);
    cycleEnd();
  endtask

  task automatic idleInputs();
    valid = '0; push = '0; data = '0; full = '0; empty = 4'hF;
    cfgWe = 1'b0; cfgTree = '0; cfgFifo = '0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic doRemap(input int tr, input int ff);
    int n;
    cfgWe = 1'b1; cfgTree = 2'(tr); cfgFifo = 2'(ff);
    stepModel("remap req");
    cfgWe = 1'b0;
    n = 0;
    while (mPend && n < 40) begin
      stepModel("remap wait");
      n++;
    end
    if (n >= 40) check("remap timeout", 128'(1), 128'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       push;
    logic [3:0][15:0] data;
    logic [3:0]       full;
    logic [3:0]       expReady;
    logic [3:0]       expPush;
    logic [3:0][18:0] expData;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic [3:0] v, logic [3:0] p, logic [63:0] d, logic [3:0] f,
                                 logic [3:0] er, logic [3:0] ep, logic [75:0] ed);
    vec_t r;
    r.valid = v; r.push = p; r.data = d; r.full = f;
    r.expReady = er; r.expPush = ep; r.expData = ed;
    return r;
  endfunction

  int ord[6];

  initial begin
    rstN = 1'b0;
    idleInputs();

    // Reset state: outputs quiet even with requests present.
    valid = 4'hF; push = 4'hF; data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(negedge clk);
    #2;
    check("reset ready", 128'(ready), 128'(0));
    check("reset push",  128'(fifoPush), 128'(0));
    check("reset data",  128'(fifoData), 128'(0));
    check("reset busy",  128'(busy), 128'(0));
    check("reset state", 128'(dbgState), 128'(0));
    @(negedge clk);
    rstN = 1'b1;
    idleInputs();
    modelReset();

    // Hand-computed table from reset defaults (rr=0, map[t]=t).
    vecs.push_back(mkVec(4'hF, 4'hF, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 4'h0, 4'hF, 4'hF,
                         {1'b1, 2'd3, 16'h0044, 1'b1, 2'd2, 16'h0033, 1'b1, 2'd1, 16'h0022, 1'b1, 2'd0, 16'h0011}));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(4'b0010, 4'b0000, {16'h0, 16'h0, 16'hBEEF, 16'h0}, 4'b0010, 4'h0, 4'h0, '0));
    vecs.push_back(mkVec(4'b0010, 4'b0000, {16'h0, 16'h0, 16'hBEEF, 16'h0}, 4'b0000, 4'b0010, 4'b0010,
                         {19'h0, 19'h0, 1'b0, 2'd1, 16'h0000, 19'h0}));
    vecs.push_back(mkVec(4'b0101, 4'b0101, {16'h0, 16'h5A5A, 16'h0, 16'hA5A5}, 4'b0100, 4'b0001, 4'b0001,
                         {19'h0, 19'h0, 19'h0, 1'b1, 2'd0, 16'hA5A5}));
    vecs.push_back(mkVec(4'h0, 4'h0, '0, 4'h0, 4'h0, 4'h0, '0));

    foreach (vecs[i]) begin
      valid = vecs[i].valid; push = vecs[i].push; data = vecs[i].data; full = vecs[i].full;
      #2;
      check($sformatf("vec%0d ready", i), 128'(ready), 128'(vecs[i].expReady));
      check($sformatf("vec%0d push", i),  128'(fifoPush), 128'(vecs[i].expPush));
      check($sformatf("vec%0d data", i),  128'(fifoData), 128'(vecs[i].expData));
      check($sformatf("vec%0d busy", i),  128'(busy), 128'(0));
      @(negedge clk);
    end

    // Three trees sharing FIFO 0: strict rotation, one push per cycle.
    doReset();
    doRemap(1, 0);
    doRemap(2, 0);
    ord = '{0, 1, 2, 0, 1, 2};
    valid = 4'b0111; push = 4'b0111; data = {16'h0, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    for (int i = 0; i < 6; i++) begin
      cycleBegin($sformatf("shared%0d", i));
      check($sformatf("shared%0d order", i), 128'(ready), 128'(4'b0001 << ord[i]));
      check($sformatf("shared%0d fifo", i), 128'(fifoPush), 128'(4'b0001));
      cycleEnd();
    end
    idleInputs();
    stepModel("shared idle");

    // Remap tree 2 -> FIFO 3 while FIFO 2 stays non-empty for 3 cycles.
    doReset();
    valid = 4'b0100; push = 4'b0100; data = {16'h0, 16'h0777, 16'h0, 16'h0};
    empty = 4'b1011; cfgWe = 1'b1; cfgTree = 2'd2; cfgFifo = 2'd3;
    cycleBegin("remap A");
    check("remap A ready", 128'(ready), 128'(4'b0100));
    cycleEnd();
    cfgWe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycleBegin($sformatf("drain%0d", i));
      check($sformatf("drain%0d busy", i), 128'(busy), 128'(1));
      check($sformatf("drain%0d blocked", i), 128'(ready[2]), 128'(0));
      cycleEnd();
    end
    empty = 4'hF;
    cycleBegin("drain empty");
    check("drain empty busy", 128'(busy), 128'(1));
    cycleEnd();
    cycleBegin("commit");
    check("commit busy", 128'(busy), 128'(1));
    check("commit blocked", 128'(ready), 128'(0));
    cycleEnd();
    cycleBegin("after commit");
    check("after commit busy", 128'(busy), 128'(0));
    check("after commit fifo", 128'(fifoPush), 128'(4'b1000));
    check("after commit data", 128'(fifoData[3]), 128'({1'b1, 2'd2, 16'h0777}));
    cycleEnd();

    // Same-fifo request and a request while busy are both dropped.
    idleInputs();
    cfgWe = 1'b1; cfgTree = 2'd2; cfgFifo = 2'd3;
    stepModel("nop req");
    cfgWe = 1'b0;
    cycleBegin("nop after");
    check("nop busy", 128'(busy), 128'(0));
    cycleEnd();
    cfgWe = 1'b1; cfgTree = 2'd0; cfgFifo = 2'd1; empty = 4'b1110;
    cycleBegin("r0 req");
    check("r0 busy0", 128'(busy), 128'(0));
    cycleEnd();
    cfgWe = 1'b0;
    cycleBegin("r0 drain");
    check("r0 busy1", 128'(busy), 128'(1));
    cycleEnd();
    cfgWe = 1'b1; cfgTree = 2'd3; cfgFifo = 2'd0;
    cycleBegin("busy req");
    check("r0 busy2", 128'(busy), 128'(1));
    cycleEnd();
    cfgWe = 1'b0; empty = 4'hF;
    cycleBegin("r0 empty");
    check("r0 busy3", 128'(busy), 128'(1));
    cycleEnd();
    cycleBegin("r0 commit");
    check("r0 busy4", 128'(busy), 128'(1));
    cycleEnd();
    cycleBegin("r0 done");
    check("r0 busy5", 128'(busy), 128'(0));
    cycleEnd();
    valid = 4'b1001; push = 4'b1001; data = {16'h0D0D, 16'h0, 16'h0, 16'h0E0E};
    cycleBegin("map check");
    check("map check fifo", 128'(fifoPush), 128'(4'b1010));
    check("map check data1", 128'(fifoData[1]), 128'({1'b1, 2'd0, 16'h0E0E}));
    cycleEnd();

    // Reset while draining: outputs drop at once, map returns to defaults.
    idleInputs();
    empty = 4'b1101; cfgWe = 1'b1; cfgTree = 2'd1; cfgFifo = 2'd2;
    stepModel("rst req");
    cfgWe = 1'b0; valid = 4'hF; push = 4'hF; data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    cycleBegin("rst drain");
    check("rst drain busy", 128'(busy), 128'(1));
    #1 rstN = 1'b0;
    #1;
    check("midrst ready", 128'(ready), 128'(0));
    check("midrst push",  128'(fifoPush), 128'(0));
    check("midrst data",  128'(fifoData), 128'(0));
    check("midrst busy",  128'(busy), 128'(0));
    check("midrst state", 128'(dbgState), 128'(0));
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    empty = 4'hF;
    cycleBegin("post rst");
    check("post rst fifo", 128'(fifoPush), 128'(4'hF));
    check("post rst data1", 128'(fifoData[1]), 128'({1'b1, 2'd1, 16'h0002}));
    cycleEnd();

    // Randomized traffic and remaps against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      for (int t = 0; t < 4; t++) begin
        valid[t] = ($urandom_range(0, 3) != 0);
        push[t]  = $urandom_range(0, 1) == 1;
        data[t]  = 16'($urandom);
        full[t]  = ($urandom_range(0, 4) == 0);
        empty[t] = ($urandom_range(0, 3) != 0);
      end
      cfgWe   = ($urandom_range(0, 7) == 0);
      cfgTree = 2'($urandom_range(0, 3));
      cfgFifo = 2'($urandom_range(0, 3));
      stepModel($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
